// File: rtl/aexm_pkg.sv
// Shared definitions for the aeMB data-cache arbiter.
// Holds the mode constants, the state encoding and a width helper.
package aexm_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CYCLE = 1'b1
  } arb_state_t;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/aexm_rr_pick.sv
// Combinational request picker for the dcache arbiter.
// Scans from start (round-robin) or from zero (fixed priority).
module aexm_rr_pick
  import aexm_pkg::*;
#(
  parameter int NCORE    = 2,
  parameter int ARB_MODE = ARB_RR,
  localparam int IW      = clog2(NCORE)
) (
  input  logic [NCORE-1:0] req,
  input  logic [IW-1:0]    start,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_idx
);

  logic [IW-1:0] base;
  logic [IW:0]   pos;
  logic [IW-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    pos         = '0;
    idx         = '0;
    base        = (ARB_MODE == ARB_FIXED) ? '0 : start;
    for (int k = 0; k < NCORE; k++) begin
      pos = {1'b0, base} + (IW+1)'(k);
      if (pos >= (IW+1)'(NCORE))
        pos = pos - (IW+1)'(NCORE);
      idx = pos[IW-1:0];
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/aexm_dcache_arbiter.sv
// Shares one dcache port among NCORE aeMB cores using the
// precycle/cycle/busy_n protocol with registered ownership.
module aexm_dcache_arbiter
  import aexm_pkg::*;
#(
  parameter int NCORE    = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [NCORE-1:0]    core_precycle_enable,
  input  logic [NCORE*AW-1:0] core_precycle_addr,
  input  logic [NCORE*AW-1:0] core_cycle_addr,
  input  logic [NCORE-1:0]    core_cycle_we,
  input  logic [NCORE*DW-1:0] core_datao,
  output logic [NCORE*DW-1:0] core_datai,
  output logic [NCORE-1:0]    core_busy_n,
  output logic                cache_precycle_enable,
  output logic [AW-1:0]       cache_precycle_addr,
  output logic [AW-1:0]       cache_cycle_addr,
  output logic                cache_cycle_we,
  output logic [DW-1:0]       cache_datao,
  input  logic [DW-1:0]       cache_datai,
  input  logic                cache_busy_n
);

  localparam int IW = clog2(NCORE);

  arb_state_t    state_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] rr_next;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic          grant;

  logic [NCORE-1:0]       is_win;
  logic [NCORE-1:0]       is_own;
  logic [NCORE:0][AW-1:0] pre_or;
  logic [NCORE:0][AW-1:0] cyc_or;
  logic [NCORE:0][DW-1:0] dat_or;

  aexm_rr_pick #(
    .NCORE    (NCORE),
    .ARB_MODE (ARB_MODE)
  ) u_pick (
    .req         (core_precycle_enable),
    .start       (rr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Back-to-back grants are allowed on the last cycle of a transfer.
  assign grant = !sys_rst_i && grant_valid &&
                 (state_q == IDLE || cache_busy_n);

  always_comb begin
    if (int'(grant_idx) == NCORE - 1)
      rr_next = '0;
    else
      rr_next = grant_idx + IW'(1);
  end

  assign pre_or[0] = '0;
  assign cyc_or[0] = '0;
  assign dat_or[0] = '0;

  for (genvar g = 0; g < NCORE; g++) begin : g_lane
    localparam logic [IW-1:0] ID = IW'(g);

    assign is_win[g] = grant && (grant_idx == ID);
    assign is_own[g] = !sys_rst_i && state_q == CYCLE &&
                       owner_q == ID;

    assign pre_or[g+1] = pre_or[g] |
      ({AW{is_win[g]}} & core_precycle_addr[g*AW +: AW]);
    assign cyc_or[g+1] = cyc_or[g] |
      ({AW{is_own[g]}} & core_cycle_addr[g*AW +: AW]);
    assign dat_or[g+1] = dat_or[g] |
      ({DW{is_own[g]}} & core_datao[g*DW +: DW]);

    assign core_busy_n[g] = sys_rst_i |
      !((is_own[g] && !cache_busy_n) ||
        (core_precycle_enable[g] && !is_win[g]));

    assign core_datai[g*DW +: DW] = cache_datai;
  end

  assign cache_precycle_enable = grant;
  assign cache_precycle_addr   = pre_or[NCORE];
  assign cache_cycle_addr      = cyc_or[NCORE];
  assign cache_datao           = dat_or[NCORE];
  assign cache_cycle_we        = |(is_own & core_cycle_we);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else if (grant) begin
      state_q <= CYCLE;
      owner_q <= grant_idx;
      if (ARB_MODE == ARB_RR)
        rr_q <= rr_next;
    end else if (state_q == CYCLE && cache_busy_n) begin
      state_q <= IDLE;
    end
  end

endmodule

// File: tb/tb_aexm_dcache_arbiter.sv
// Scoreboard bench for the dcache arbiter: three instances
// (2-core RR, 2-core fixed, 3-core RR) share one stimulus set.
module tb_aexm_dcache_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [31:0] pa [3];
  logic [31:0] ca [3];
  logic [31:0] dout [3];
  logic [31:0] cdi;
  logic        cbn;

  logic [63:0] a0_di, a1_di;
  logic [95:0] a2_di;
  logic [1:0]  a0_bn, a1_bn;
  logic [2:0]  a2_bn;
  logic        a0_pe, a1_pe, a2_pe;
  logic [31:0] a0_pa, a1_pa, a2_pa;
  logic [31:0] a0_ca, a1_ca, a2_ca;
  logic        a0_we, a1_we, a2_we;
  logic [31:0] a0_d, a1_d, a2_d;

  aexm_dcache_arbiter #(.NCORE(2), .ARB_MODE(0)) u_rr2 (
    .sys_clk_i             (clk),
    .sys_rst_i             (rst),
    .core_precycle_enable  (req[1:0]),
    .core_precycle_addr    ({pa[1], pa[0]}),
    .core_cycle_addr       ({ca[1], ca[0]}),
    .core_cycle_we         (we[1:0]),
    .core_datao            ({dout[1], dout[0]}),
    .core_datai            (a0_di),
    .core_busy_n           (a0_bn),
    .cache_precycle_enable (a0_pe),
    .cache_precycle_addr   (a0_pa),
    .cache_cycle_addr      (a0_ca),
    .cache_cycle_we        (a0_we),
    .cache_datao           (a0_d),
    .cache_datai           (cdi),
    .cache_busy_n          (cbn)
  );

  aexm_dcache_arbiter #(.NCORE(2), .ARB_MODE(1)) u_fx2 (
    .sys_clk_i             (clk),
    .sys_rst_i             (rst),
    .core_precycle_enable  (req[1:0]),
    .core_precycle_addr    ({pa[1], pa[0]}),
    .core_cycle_addr       ({ca[1], ca[0]}),
    .core_cycle_we         (we[1:0]),
    .core_datao            ({dout[1], dout[0]}),
    .core_datai            (a1_di),
    .core_busy_n           (a1_bn),
    .cache_precycle_enable (a1_pe),
    .cache_precycle_addr   (a1_pa),
    .cache_cycle_addr      (a1_ca),
    .cache_cycle_we        (a1_we),
    .cache_datao           (a1_d),
    .cache_datai           (cdi),
    .cache_busy_n          (cbn)
  );

  aexm_dcache_arbiter #(.NCORE(3), .ARB_MODE(0)) u_rr3 (
    .sys_clk_i             (clk),
    .sys_rst_i             (rst),
    .core_precycle_enable  (req),
    .core_precycle_addr    ({pa[2], pa[1], pa[0]}),
    .core_cycle_addr       ({ca[2], ca[1], ca[0]}),
    .core_cycle_we         (we),
    .core_datao            ({dout[2], dout[1], dout[0]}),
    .core_datai            (a2_di),
    .core_busy_n           (a2_bn),
    .cache_precycle_enable (a2_pe),
    .cache_precycle_addr   (a2_pa),
    .cache_cycle_addr      (a2_ca),
    .cache_cycle_we        (a2_we),
    .cache_datao           (a2_d),
    .cache_datai           (cdi),
    .cache_busy_n          (cbn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic        pe;
    logic [31:0] pa;
    logic [31:0] ca;
    logic        we;
    logic [31:0] d;
    logic [2:0]  bn;
    logic [31:0] di;
    string       nm;
  } exp_t;

  exp_t sbq [$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  logic        g_pe, g_we, g_diok;
  logic [31:0] g_pa, g_ca, g_d;
  logic [2:0]  g_bn;

  // Monitor: every negedge, drain expectations queued for this cycle.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.dut)
        0: begin
          g_pe = a0_pe; g_pa = a0_pa; g_ca = a0_ca;
          g_we = a0_we; g_d = a0_d; g_bn = {1'b1, a0_bn};
          g_diok = (a0_di == {2{e.di}});
        end
        1: begin
          g_pe = a1_pe; g_pa = a1_pa; g_ca = a1_ca;
          g_we = a1_we; g_d = a1_d; g_bn = {1'b1, a1_bn};
          g_diok = (a1_di == {2{e.di}});
        end
        default: begin
          g_pe = a2_pe; g_pa = a2_pa; g_ca = a2_ca;
          g_we = a2_we; g_d = a2_d; g_bn = a2_bn;
          g_diok = (a2_di == {3{e.di}});
        end
      endcase
      checks++;
      if (g_pe !== e.pe || g_pa !== e.pa || g_ca !== e.ca ||
          g_we !== e.we || g_d !== e.d || g_bn !== e.bn ||
          g_diok !== 1'b1) begin
        failures++;
        $display("FAIL %s dut%0d got pe=%0b pa=%h ca=%h we=%0b d=%h bn=%b di_ok=%0b want pe=%0b pa=%h ca=%h we=%0b d=%h bn=%b di_ok=1",
                 e.nm, e.dut, g_pe, g_pa, g_ca, g_we, g_d, g_bn, g_diok,
                 e.pe, e.pa, e.ca, e.we, e.d, e.bn);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int dut, input logic epe,
                     input logic [31:0] epa, input logic [31:0] eca,
                     input logic ewe, input logic [31:0] ed,
                     input logic [2:0] ebn, input string nm);
    exp_t x;
    x.dut = dut; x.pe = epe; x.pa = epa; x.ca = eca;
    x.we = ewe; x.d = ed; x.bn = ebn; x.di = cdi; x.nm = nm;
    sbq.push_back(x);
  endtask

  task automatic do_reset(input string nm);
    tick();
    rst = 1'b1; req = '0; cbn = 1'b1;
    for (int k = 0; k < 3; k++)
      chk(k, 0, 0, 0, 0, 0, 3'b111, nm);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; cbn = 1'b1; cdi = '0;
    for (int k = 0; k < 3; k++) begin
      pa[k] = 32'h100 * (k + 1);
      ca[k] = 32'h100 * (k + 1);
      dout[k] = '0;
    end
    do_reset("reset");

    // Uncontended read by core0 (DUT0)
    req = 3'b001; cdi = 32'h1111_1111;
    chk(0, 1, 32'h100, 0, 0, 0, 3'b111, "rd_pre");
    tick(); req = 3'b000;
    chk(0, 0, 0, 32'h100, 0, 0, 3'b111, "rd_cyc");
    tick();
    chk(0, 0, 0, 0, 0, 0, 3'b111, "rd_idle");

    // Both request continuously, round-robin alternates
    tick(); req = 3'b011; cdi = 32'h2222_2222;
    chk(0, 1, 32'h200, 0, 0, 0, 3'b110, "rr_g1");
    tick();
    chk(0, 1, 32'h100, 32'h200, 0, 0, 3'b101, "rr_g0");
    tick();
    chk(0, 1, 32'h200, 32'h100, 0, 0, 3'b110, "rr_g1b");
    tick();
    chk(0, 1, 32'h100, 32'h200, 0, 0, 3'b101, "rr_g0b");
    tick(); req = 3'b000;
    chk(0, 0, 0, 32'h100, 0, 0, 3'b111, "rr_tail");
    tick();
    chk(0, 0, 0, 0, 0, 0, 3'b111, "rr_idle");

    // Core1 write held busy 3 cycles, core0 arrives mid-window
    tick(); req = 3'b010; we = 3'b010; dout[1] = 32'hDEAD_BEEF;
    cdi = 32'h3333_3333;
    chk(0, 1, 32'h200, 0, 0, 0, 3'b111, "wr_pre");
    tick(); req = 3'b000; cbn = 1'b0;
    chk(0, 0, 0, 32'h200, 1, 32'hDEAD_BEEF, 3'b101, "wr_busy1");
    tick(); req = 3'b001;
    chk(0, 0, 0, 32'h200, 1, 32'hDEAD_BEEF, 3'b100, "wr_busy2");
    tick();
    chk(0, 0, 0, 32'h200, 1, 32'hDEAD_BEEF, 3'b100, "wr_busy3");
    tick(); cbn = 1'b1;
    chk(0, 1, 32'h100, 32'h200, 1, 32'hDEAD_BEEF, 3'b111, "wr_rel");
    tick(); req = 3'b000;
    chk(0, 0, 0, 32'h100, 0, 0, 3'b111, "wr_next");
    tick(); we = 3'b000; dout[1] = '0;
    chk(0, 0, 0, 0, 0, 0, 3'b111, "wr_idle");

    // Fixed priority: core0 always wins (DUT1)
    do_reset("reset_fx");
    req = 3'b011; cdi = 32'h4444_4444;
    chk(1, 1, 32'h100, 0, 0, 0, 3'b101, "fx_c1");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk(1, 1, 32'h100, 32'h100, 0, 0, 3'b101, "fx_cn");
    end
    tick(); req = 3'b000;
    chk(1, 0, 0, 32'h100, 0, 0, 3'b111, "fx_tail");
    tick();
    chk(1, 0, 0, 0, 0, 0, 3'b111, "fx_idle");

    // Three cores, rr_q=2 after a core1 grant: order 2,0,1 (DUT2)
    do_reset("reset_3");
    req = 3'b010; cdi = 32'h5555_5555;
    chk(2, 1, 32'h200, 0, 0, 0, 3'b111, "n3_g1");
    tick(); req = 3'b111;
    chk(2, 1, 32'h300, 32'h200, 0, 0, 3'b100, "n3_g2");
    tick();
    chk(2, 1, 32'h100, 32'h300, 0, 0, 3'b001, "n3_g0");
    tick();
    chk(2, 1, 32'h200, 32'h100, 0, 0, 3'b010, "n3_g1b");
    tick(); req = 3'b000;
    chk(2, 0, 0, 32'h200, 0, 0, 3'b111, "n3_tail");
    tick();
    chk(2, 0, 0, 0, 0, 0, 3'b111, "n3_idle");

    // Reset during a pending write (DUT0)
    tick(); req = 3'b001; we = 3'b001; dout[0] = 32'hCAFE_F00D;
    cdi = 32'h6666_6666;
    chk(0, 1, 32'h100, 0, 0, 0, 3'b111, "rw_pre");
    tick(); req = 3'b000; cbn = 1'b0;
    chk(0, 0, 0, 32'h100, 1, 32'hCAFE_F00D, 3'b110, "rw_busy");
    tick(); rst = 1'b1;
    chk(0, 0, 0, 0, 0, 0, 3'b111, "rw_rst");
    tick(); rst = 1'b0; cbn = 1'b1;
    chk(0, 0, 0, 0, 0, 0, 3'b111, "rw_after");
    tick(); req = 3'b011;
    chk(0, 1, 32'h100, 0, 0, 0, 3'b101, "rw_rr0");
    tick(); req = 3'b000;
    chk(0, 0, 0, 32'h100, 1, 32'hCAFE_F00D, 3'b111, "rw_cyc");
    tick();
    chk(0, 0, 0, 0, 0, 0, 3'b111, "rw_idle");

    for (int k = 0; k < 5 && sbq.size() > 0; k++)
      @(posedge clk);
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0",
               sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
